dram_controller: RTL and testbench

DRAM_CONTROLLER -- requirements
Module: dram_controller

---
 rtl/dram_controller.sv | 102 ++++++++++
 tb/tb_dram_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_controller.sv
// Fixed-latency line-wide memory model standing behind an L1 cache controller.
// Performs one read or write per request and answers with a single-cycle ack.
module dram_controller #(
    parameter int LINE_W  = 128,
    parameter int INDEX_W = 10,
    parameter int LATENCY = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dram_cs,
    input  logic              dram_we,
    input  logic [31:0]       dram_addr,
    input  logic [LINE_W-1:0] dram_wdata,
    output logic [LINE_W-1:0] dram_rdata,
    output logic              dram_ack,
    output logic              dram_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_count;
    logic                r_we;
    logic [INDEX_W-1:0]  r_index;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_rdata;
    logic [LINE_W-1:0]   r_mem [0:(2**INDEX_W)-1];

    logic                w_accept;
    logic                w_done;
    logic                w_unused_addr;

    assign w_accept      = (r_state == IDLE) && dram_cs;
    assign w_done        = (r_state == BUSY) && (r_count == 8'd0);
    assign w_unused_addr = ^{dram_addr[31:INDEX_W+4], dram_addr[3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (dram_cs) w_state_next = BUSY;
            BUSY:    if (r_count == 8'd0) w_state_next = ACK;
            ACK:     w_state_next = dram_cs ? RELEASE : IDLE;
            RELEASE: if (!dram_cs) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (w_accept) begin
            r_count <= COUNT_LOAD;
        end else if ((r_state == BUSY) && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    // Request fields are captured once so later bus changes cannot leak into the access.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_we    <= dram_we;
            r_index <= dram_addr[INDEX_W+3:4];
            r_wdata <= dram_wdata;
        end
    end

    // Storage is never reset; a reset on the ACK-entry edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && w_done && r_we) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_done && !r_we) begin
            r_rdata <= r_mem[r_index];
        end
    end

    assign dram_rdata = r_rdata;
    assign dram_ack   = (r_state == ACK);
    assign dram_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_dram_controller.sv
// Bench for dram_controller: a LATENCY=4 instance and a LATENCY=1 instance
// checked against a line-array model with table, hand-written and random requests.
module tb_dram_controller;

    localparam logic [127:0] A5 = {8{16'hA5A5}};
    localparam logic [127:0] D1 = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, cs, we, sel;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata0, rdata1, rdata;
    logic         ack0, ack1, ack, busy0, busy1, busy;
    logic         cs0, cs1;

    assign cs0   = cs & ~sel;
    assign cs1   = cs & sel;
    assign rdata = sel ? rdata1 : rdata0;
    assign ack   = sel ? ack1 : ack0;
    assign busy  = sel ? busy1 : busy0;

    dram_controller #(.LINE_W(128), .INDEX_W(4), .LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .dram_cs(cs0), .dram_we(we), .dram_addr(addr),
        .dram_wdata(wdata), .dram_rdata(rdata0), .dram_ack(ack0), .dram_busy(busy0)
    );

    dram_controller #(.LINE_W(128), .INDEX_W(4), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .dram_cs(cs1), .dram_we(we), .dram_addr(addr),
        .dram_wdata(wdata), .dram_rdata(rdata1), .dram_ack(ack1), .dram_busy(busy1)
    );

    int errors = 0;
    int checks = 0;

    // Reference: one line array and last-read register per instance.
    logic [127:0] model_mem [2][16];
    logic [127:0] model_rd  [2];

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           hold;
        logic [127:0] exp_rd;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_apply(input logic twe, input logic [31:0] taddr, input logic [127:0] twd);
        if (twe) model_mem[sel][taddr[7:4]] = twd;
        else     model_rd[sel] = model_mem[sel][taddr[7:4]];
    endtask

    task automatic model_reset();
        model_rd[0] = '0;
        model_rd[1] = '0;
    endtask

    // Issue one request starting at a negedge; scramble the bus while busy.
    task automatic txn(input logic twe, input logic [31:0] taddr, input logic [127:0] twd,
                       input int hold, input logic [127:0] exp_rd, input string tag);
        int lat, n, busy_n;
        lat    = sel ? 1 : 4;
        cs     = 1'b1;
        we     = twe;
        addr   = taddr;
        wdata  = twd;
        n      = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (n == 1) begin
                addr  = $urandom;
                wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end while (!ack && n < lat + 8);
        check($sformatf("%s ack_latency", tag), 128'(n - 1), 128'(lat));
        check($sformatf("%s busy_cycles", tag), 128'(busy_n), 128'(lat + 1));
        check($sformatf("%s rdata_at_ack", tag), rdata, exp_rd);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("%s release_busy_ack", tag), {busy, ack}, 2'b10);
        end
        cs = 1'b0;
        @(negedge clk);
        check($sformatf("%s back_idle", tag), {busy, ack}, 2'b00);
        check($sformatf("%s rdata_held", tag), rdata, exp_rd);
        $display("txn %s lat=%0d we=%0d addr=%h hold=%0d rdata=%h", tag, lat, twe, taddr, hold, rdata);
    endtask

    task automatic mtxn(input logic twe, input logic [31:0] taddr, input logic [127:0] twd,
                        input int hold, input string tag);
        logic [127:0] exp;
        exp = twe ? model_rd[sel] : model_mem[sel][taddr[7:4]];
        txn(twe, taddr, twd, hold, exp, tag);
        model_apply(twe, taddr, twd);
    endtask

    initial begin
        int n, acks;
        logic         rwe;
        logic [31:0]  raddr;
        logic [127:0] rwd;

        for (int i = 0; i < 16; i++) begin
            model_mem[0][i] = '0;
            model_mem[1][i] = '0;
        end
        model_reset();

        vecs[0] = '{1'b1, 32'h0000_0030, A5,  0, 128'h0};
        vecs[1] = '{1'b0, 32'h0000_0030, '0,  3, A5};
        vecs[2] = '{1'b0, 32'h0000_0130, '0,  0, A5};
        vecs[3] = '{1'b1, 32'h0000_0050, D1,  1, A5};
        vecs[4] = '{1'b0, 32'h0000_005C, '0,  0, D1};
        vecs[5] = '{1'b0, 32'hFFFF_FF10, '0,  0, 128'h0};

        sel = 1'b0; rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset dut0", {busy0, ack0, rdata0}, '0);
        check("reset dut1", {busy1, ack1, rdata1}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, vecs[i].exp_rd,
                $sformatf("vec%0d", i));
            model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata);
        end

        // Reset two cycles into a write aborts it.
        cs = 1'b1; we = 1'b1; addr = 32'h40; wdata = {4{32'hDEADBEEF}};
        repeat (2) @(negedge clk);
        check("abort busy_before_rst", busy, 1'b1);
        rst = 1'b1; cs = 1'b0;
        @(negedge clk);
        check("abort after_rst", {busy, ack, rdata}, '0);
        model_reset();
        rst = 1'b0;
        acks = 0;
        repeat (6) begin @(negedge clk); if (ack) acks++; end
        check("abort no_ack", 128'(acks), 128'd0);
        $display("txn abort_write addr=00000040 acks=%0d", acks);
        mtxn(1'b0, 32'h40, '0, 0, "read_after_abort");

        // Reset on the ACK-entry edge wins.
        cs = 1'b1; we = 1'b1; addr = 32'h60; wdata = {4{32'h12345678}};
        repeat (4) @(negedge clk);
        check("ackrst busy_no_ack", {busy, ack}, 2'b10);
        rst = 1'b1; cs = 1'b0;
        @(negedge clk);
        check("ackrst suppressed", {busy, ack}, 2'b00);
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        $display("txn ack_edge_reset addr=00000060 busy=%0d ack=%0d", busy, ack);
        mtxn(1'b0, 32'h60, '0, 0, "read_after_ackrst");

        // cs during reset is not accepted; acceptance follows the release.
        rst = 1'b1; cs = 1'b1; we = 1'b0; addr = 32'h30;
        @(negedge clk);
        check("rstcs no_accept", busy, 1'b0);
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        check("rstcs accept_after", busy, 1'b1);
        n = 1;
        while (!ack && n < 12) begin @(negedge clk); n++; end
        check("rstcs ack_latency", 128'(n - 1), 128'd4);
        model_apply(1'b0, 32'h30, '0);
        check("rstcs rdata", rdata, model_rd[0]);
        cs = 1'b0;
        @(negedge clk);
        $display("txn read_after_rst_release addr=00000030 rdata=%h", rdata);

        for (int i = 0; i < 30; i++) begin
            rwe        = 1'($urandom_range(0, 1));
            raddr      = $urandom;
            raddr[7:4] = 4'($urandom_range(0, 3));
            rwd        = {$urandom, $urandom, $urandom, $urandom};
            mtxn(rwe, raddr, rwd, $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        sel = 1'b1;
        @(negedge clk);
        rwd = {$urandom, $urandom, $urandom, $urandom};
        mtxn(1'b1, 32'h20, rwd, 0, "lat1_write");
        mtxn(1'b0, 32'h20, '0, 1, "lat1_read");
        check("lat1 read_returns_write", rdata, rwd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
